// File: rtl/gen_clk_multi_if.sv
// Run request and divided-clock outputs of gen_clk_multi, grouped for the PHY clocking fabric.
interface gen_clk_multi_if #(
  parameter int unsigned NUM_OUT = 2
) ();
  logic               enable;
  logic [NUM_OUT-1:0] clk_out;
  logic [NUM_OUT-1:0] rise_stb;
  logic               locked;

  modport master (output enable, input clk_out, input rise_stb, input locked);
  modport slave  (input enable, output clk_out, output rise_stb, output locked);
endinterface

// File: rtl/gen_clk_multi.sv
// Divided-clock family generator: clk_out[k] = clk_8f / 2^(FIRST_DIV_LOG2+k), with rise strobes,
// a lock flag and an optional graceful stop that drains to the common low phase.
module gen_clk_multi #(
  parameter int unsigned NUM_OUT        = 2,
  parameter int unsigned FIRST_DIV_LOG2 = 2,
  parameter bit          STOP_MODE      = 1'b0
) (
  input  logic           clk_8f,
  input  logic           reset_L,
  gen_clk_multi_if.slave bus
);

  localparam int unsigned CW  = FIRST_DIV_LOG2 + NUM_OUT - 1;
  localparam int unsigned LSB = FIRST_DIV_LOG2 - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_d, state_q;
  logic [CW-1:0]      cnt_d, cnt_q, nxt;
  logic [NUM_OUT-1:0] clk_out_d, clk_out_q;
  logic [NUM_OUT-1:0] rise_d, rise_q;
  logic               locked_d, locked_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    rise_d    = '0;
    nxt       = cnt_q + CW'(1);

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_out_d = '0;
        if (bus.enable) state_d = StRun;
      end
      StRun, StDrain: begin
        // Each output is one counter bit, so the family shares a common low at counter wrap.
        cnt_d     = nxt;
        clk_out_d = nxt[CW-1:LSB];
        rise_d    = nxt[CW-1:LSB] & ~clk_out_q;
        if (bus.enable) begin
          state_d = StRun;
        end else if (!STOP_MODE) begin
          state_d   = StIdle;
          cnt_d     = '0;
          clk_out_d = '0;
          rise_d    = '0;
        end else if (nxt == '0) begin
          state_d = StIdle;
        end else begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase

    locked_d = (state_d == StRun);
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clk_out_q <= '0;
      rise_q    <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.rise_stb = rise_q;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_gen_clk_multi.sv
// Drives three gen_clk_multi configurations with random run requests and compares every cycle
// against a phase-position model of the divided-clock family.
module tb_gen_clk_multi;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance configurations: default, graceful stop, and 4 outputs from clk_8f/2.
  int nout[NI] = '{2, 2, 4};
  int fdl[NI]  = '{2, 2, 1};
  int sm[NI]   = '{0, 1, 0};

  logic       en[NI];
  logic [3:0] d_clk[NI];
  logic [3:0] d_rs[NI];
  logic       d_lk[NI];

  // Model: run mode (0 idle, 1 run, 2 drain) and phase position within the longest period.
  int         st[NI];
  int         ph[NI];
  logic [3:0] m_clk[NI];
  logic [3:0] m_rs[NI];
  logic       m_lk[NI];

  int n_run  = 0;
  int n_fail = 0;

  gen_clk_multi_if #(.NUM_OUT(2)) if0 ();
  gen_clk_multi_if #(.NUM_OUT(2)) if1 ();
  gen_clk_multi_if #(.NUM_OUT(4)) if2 ();

  gen_clk_multi #(.NUM_OUT(2), .FIRST_DIV_LOG2(2), .STOP_MODE(1'b0)) u_dut0 (
    .clk_8f(clk), .reset_L(rst_n), .bus(if0)
  );
  gen_clk_multi #(.NUM_OUT(2), .FIRST_DIV_LOG2(2), .STOP_MODE(1'b1)) u_dut1 (
    .clk_8f(clk), .reset_L(rst_n), .bus(if1)
  );
  gen_clk_multi #(.NUM_OUT(4), .FIRST_DIV_LOG2(1), .STOP_MODE(1'b0)) u_dut2 (
    .clk_8f(clk), .reset_L(rst_n), .bus(if2)
  );

  assign if0.enable = en[0];
  assign if1.enable = en[1];
  assign if2.enable = en[2];
  assign d_clk[0] = 4'(if0.clk_out);
  assign d_clk[1] = 4'(if1.clk_out);
  assign d_clk[2] = 4'(if2.clk_out);
  assign d_rs[0]  = 4'(if0.rise_stb);
  assign d_rs[1]  = 4'(if1.rise_stb);
  assign d_rs[2]  = 4'(if2.rise_stb);
  assign d_lk[0]  = if0.locked;
  assign d_lk[1]  = if1.locked;
  assign d_lk[2]  = if2.locked;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output k is high in the upper half of its own period 2^(f+k).
  function automatic logic [3:0] wave(input int p, input int f, input int n);
    logic [3:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      int half;
      half = 1 << (f - 1 + k);
      w[k] = (p % (2 * half)) >= half;
    end
    return w;
  endfunction

  task automatic model_idle(input int i);
    st[i] = 0; ph[i] = 0; m_clk[i] = '0; m_rs[i] = '0;
  endtask

  task automatic model_step(input int i);
    int per, np;
    logic [3:0] w;
    per = 1 << (fdl[i] + nout[i] - 1);
    if (!rst_n) begin
      model_idle(i);
    end else if (st[i] == 0) begin
      model_idle(i);
      if (en[i]) st[i] = 1;
    end else if (!en[i] && sm[i] == 0) begin
      model_idle(i);
    end else begin
      np = (ph[i] + 1) % per;
      w  = wave(np, fdl[i], nout[i]);
      m_rs[i]  = w & ~m_clk[i];
      m_clk[i] = w;
      ph[i]    = np;
      if (en[i])        st[i] = 1;
      else if (np == 0) st[i] = 0;
      else              st[i] = 2;
    end
    m_lk[i] = (st[i] == 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("clk_out%0d", i), d_clk[i], m_clk[i]);
      check_eq($sformatf("rise_stb%0d", i), d_rs[i], m_rs[i]);
      check_eq($sformatf("locked%0d", i), 4'(d_lk[i]), 4'(m_lk[i]));
    end
  endtask

  initial begin
    int step0, step1;
    bit found;
    for (int i = 0; i < NI; i++) begin
      en[i] = 1'b0;
      model_idle(i);
      m_lk[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq("rst_clk_out", d_clk[i], 4'h0);
      check_eq("rst_rise_stb", d_rs[i], 4'h0);
      check_eq("rst_locked", 4'(d_lk[i]), 4'h0);
    end
    rst_n = 1'b1;

    // Enable held low in idle: everything frozen.
    repeat (3) cycle();

    for (int i = 0; i < NI; i++) en[i] = 1'b1;
    cycle();
    check_eq("entry_clk0", d_clk[0], 4'h0);
    check_eq("entry_lock0", 4'(d_lk[0]), 4'h1);
    cycle();
    check_eq("lat1_clk0", d_clk[0], 4'h0);
    cycle();
    check_eq("lat2_clk0", d_clk[0], 4'h1);
    check_eq("lat2_rise0", d_rs[0], 4'h1);
    cycle();
    check_eq("lat3_rise0", d_rs[0], 4'h0);
    repeat (20) cycle();

    // Immediate stop at cnt=5 then restart; graceful stop at cnt=1, resume at cnt=4,
    // then a second graceful stop left to drain fully.
    step0 = 0;
    step1 = 0;
    for (int c = 0; c < 60; c++) begin
      if (step0 == 0 && st[0] == 1 && ph[0] == 5) begin
        en[0] = 1'b0; step0 = 1;
      end else begin
        en[0] = 1'b1;
      end
      if (step1 == 0 && st[1] == 1 && ph[1] == 1) begin
        en[1] = 1'b0; step1 = 1;
      end else if (step1 == 1 && st[1] == 2 && ph[1] == 4) begin
        en[1] = 1'b1; step1 = 2;
      end else if (step1 == 2 && st[1] == 1 && ph[1] == 1) begin
        en[1] = 1'b0; step1 = 3;
      end
      cycle();
    end
    check_eq("drain_done_lock1", 4'(d_lk[1]), 4'h0);
    check_eq("drain_done_clk1", d_clk[1], 4'h0);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
      end
      cycle();
    end

    // Asynchronous reset while clk_out[1] of the default instance is high.
    for (int i = 0; i < NI; i++) en[i] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (d_clk[0][1] && st[0] == 1) found = 1'b1;
    end
    check_eq("wait_clk1_high", 4'(found), 4'h1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq("async_clk_out", d_clk[i], 4'h0);
      check_eq("async_rise_stb", d_rs[i], 4'h0);
      check_eq("async_locked", 4'(d_lk[i]), 4'h0);
      model_idle(i);
      m_lk[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
